// File: rtl/i2c_poll_master.sv
// i2c_poll_master
// Single-master I2C read sequencer. Sweeps NUM_SLAVES consecutive 7-bit
// addresses starting at BASE_ADDR and performs one single-byte read per
// slave: START, address+R, slave ACK, 8 data bits, master NACK, STOP.
// Each byte is delivered on a valid/ready result port.
//
// Optional feature: define I2C_POLL_RETRY_EN to retry an address NACK once
// (STOP, then a full new START..AACK attempt for the same slave).
//
// Result handshake: res_valid/res_data/res_addr/res_err are held stable from
// the rising of res_valid until the clk edge where res_valid && res_ready are
// both high; that edge is the transfer and res_valid drops right after it.
//
// Bus outputs scl/sda_oe are registered copies of the decoded bus state, so
// the pins lag the FSM by one clk; this keeps the pins glitch-free and does
// not change any quarter-to-quarter relationship.
module i2c_poll_master #(
    parameter int         CLK_DIV    = 4,
    parameter int         NUM_SLAVES = 4,
    parameter logic [6:0] BASE_ADDR  = 7'h20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       sweep_req,
    output logic       busy,
    output logic       scl,
    output logic       sda_oe,
    input  logic       sda_in,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic [6:0] res_addr,
    output logic       res_err,
    output logic [3:0] o_dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_START = 4'd1,
        S_ADDR  = 4'd2,
        S_AACK  = 4'd3,
        S_DATA  = 4'd4,
        S_MNACK = 4'd5,
        S_STOP  = 4'd6,
        S_OUT   = 4'd7,
        S_WAIT  = 4'd8
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [2:0] LAST_IDX = 3'(NUM_SLAVES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_div;
    logic [7:0] w_div_nxt;
    logic [1:0] r_q;
    logic [1:0] w_q_nxt;
    logic [2:0] r_bit;
    logic [2:0] w_bit_nxt;
    logic [2:0] r_idx;
    logic [2:0] w_idx_nxt;
    logic [7:0] r_tx;
    logic [7:0] w_tx_nxt;
    logic [7:0] r_rx;
    logic [7:0] w_rx_nxt;
    logic       r_nack;
    logic       w_nack_nxt;
    logic       r_busy;
    logic       w_busy_nxt;
    logic       r_scl;
    logic       w_scl;
    logic       r_sda_oe;
    logic       w_sda_oe;
    logic       r_res_valid;
    logic [7:0] r_res_data;
    logic [6:0] r_res_addr;
    logic       r_res_err;
    logic       w_load_res;
    logic       w_hs;
    logic       w_tick;
    logic       w_slot_end;
    logic [6:0] w_addr;
`ifdef I2C_POLL_RETRY_EN
    logic       r_retried;
    logic       w_retried_nxt;
`endif

    // Quarter tick, end of a 4-quarter bit slot, current slave address, handshake.
    assign w_tick     = (r_div == DIV_LAST);
    assign w_slot_end = w_tick && (r_q == 2'd3);
    assign w_addr     = BASE_ADDR + {4'b0000, r_idx};
    assign w_hs       = (r_state == S_WAIT) && r_res_valid && res_ready;

    assign busy        = r_busy;
    assign scl         = r_scl;
    assign sda_oe      = r_sda_oe;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign res_addr    = r_res_addr;
    assign res_err     = r_res_err;
    assign o_dbg_state = r_state;

    // Next-state, counter/shift-register updates and bus pin decode.
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = w_tick ? 8'd0 : r_div + 8'd1;
        w_q_nxt     = w_tick ? r_q + 2'd1 : r_q;
        w_bit_nxt   = r_bit;
        w_idx_nxt   = r_idx;
        w_tx_nxt    = r_tx;
        w_rx_nxt    = r_rx;
        w_nack_nxt  = r_nack;
        w_busy_nxt  = r_busy;
        w_scl       = 1'b1;
        w_sda_oe    = 1'b0;
        w_load_res  = 1'b0;
`ifdef I2C_POLL_RETRY_EN
        w_retried_nxt = r_retried;
`endif
        case (r_state)
            S_IDLE: begin
                w_div_nxt = 8'd0;
                w_q_nxt   = 2'd0;
                if (sweep_req && en) begin
                    w_state_nxt = S_START;
                    w_idx_nxt   = 3'd0;
                    w_busy_nxt  = 1'b1;
                    w_nack_nxt  = 1'b0;
`ifdef I2C_POLL_RETRY_EN
                    w_retried_nxt = 1'b0;
`endif
                end
            end
            S_START: begin
                // SDA falls while SCL stays high, then is held for a quarter.
                w_scl    = 1'b1;
                w_sda_oe = 1'b1;
                if (w_tick && r_q == 2'd1) begin
                    w_state_nxt = S_ADDR;
                    w_q_nxt     = 2'd0;
                    w_bit_nxt   = 3'd0;
                    w_tx_nxt    = {w_addr, 1'b1};
                end
            end
            S_ADDR: begin
                w_scl    = r_q[1];
                w_sda_oe = ~r_tx[7];
                if (w_slot_end) begin
                    w_tx_nxt  = {r_tx[6:0], 1'b0};
                    w_bit_nxt = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_AACK;
                    end
                end
            end
            S_AACK: begin
                w_scl = r_q[1];
                if (w_slot_end) begin
                    if (!sda_in) begin
                        w_state_nxt = S_DATA;
                        w_bit_nxt   = 3'd0;
                    end else begin
                        w_state_nxt = S_STOP;
                        w_nack_nxt  = 1'b1;
                    end
                end
            end
            S_DATA: begin
                w_scl = r_q[1];
                if (w_slot_end) begin
                    w_rx_nxt  = {r_rx[6:0], sda_in};
                    w_bit_nxt = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_MNACK;
                    end
                end
            end
            S_MNACK: begin
                // SDA left released: NACK tells the slave the read is over.
                w_scl = r_q[1];
                if (w_slot_end) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                // SDA low through the SCL rise, released in the last quarter.
                w_scl    = r_q[1];
                w_sda_oe = (r_q != 2'd3);
                if (w_slot_end) begin
                    w_state_nxt = S_OUT;
`ifdef I2C_POLL_RETRY_EN
                    if (r_nack && !r_retried) begin
                        w_state_nxt   = S_START;
                        w_nack_nxt    = 1'b0;
                        w_retried_nxt = 1'b1;
                    end
`endif
                end
            end
            S_OUT: begin
                w_div_nxt   = 8'd0;
                w_q_nxt     = 2'd0;
                w_load_res  = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_div_nxt = 8'd0;
                w_q_nxt   = 2'd0;
                if (w_hs) begin
                    if (r_idx == LAST_IDX || !en) begin
                        w_state_nxt = S_IDLE;
                        w_busy_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = S_START;
                        w_idx_nxt   = r_idx + 3'd1;
                        w_nack_nxt  = 1'b0;
`ifdef I2C_POLL_RETRY_EN
                        w_retried_nxt = 1'b0;
`endif
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath, bus pin and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div       <= 8'd0;
            r_q         <= 2'd0;
            r_bit       <= 3'd0;
            r_idx       <= 3'd0;
            r_tx        <= 8'd0;
            r_rx        <= 8'd0;
            r_nack      <= 1'b0;
            r_busy      <= 1'b0;
            r_scl       <= 1'b1;
            r_sda_oe    <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= 8'd0;
            r_res_addr  <= 7'd0;
            r_res_err   <= 1'b0;
`ifdef I2C_POLL_RETRY_EN
            r_retried   <= 1'b0;
`endif
        end else begin
            r_div    <= w_div_nxt;
            r_q      <= w_q_nxt;
            r_bit    <= w_bit_nxt;
            r_idx    <= w_idx_nxt;
            r_tx     <= w_tx_nxt;
            r_rx     <= w_rx_nxt;
            r_nack   <= w_nack_nxt;
            r_busy   <= w_busy_nxt;
            r_scl    <= w_scl;
            r_sda_oe <= w_sda_oe;
`ifdef I2C_POLL_RETRY_EN
            r_retried <= w_retried_nxt;
`endif
            if (w_load_res) begin
                r_res_valid <= 1'b1;
                r_res_data  <= r_nack ? 8'h00 : r_rx;
                r_res_addr  <= w_addr;
                r_res_err   <= r_nack;
            end else if (w_hs) begin
                r_res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2c_poll_master.sv
// Bench for i2c_poll_master: behavioural I2C slaves on the bus, a result
// scoreboard fed by the stimulus and drained by a handshake monitor.
// DUT: CLK_DIV=4, NUM_SLAVES=4, BASE_ADDR=7'h7E -> addresses 7E,7F,00,01.
// Slaves: 7E holds A5, 7F holds 3C, 00 absent (NACK), 01 holds 5A.
module tb_i2c_poll_master;

    localparam int PH_IDLE = 0;
    localparam int PH_ADDR = 1;
    localparam int PH_ACK  = 2;
    localparam int PH_DATA = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b1;
    logic       sweep_req = 1'b0;
    logic       busy;
    logic       scl;
    logic       sda_oe;
    logic       sda_in;
    logic       res_valid;
    logic       res_ready = 1'b1;
    logic [7:0] res_data;
    logic [6:0] res_addr;
    logic       res_err;
    logic [3:0] dbg_state;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int rise_q[$];
    logic [15:0] exp_q[$];   // {err, addr[6:0], data[7:0]}

    // slave model state
    logic [7:0] mem [128];
    bit         present [128];
    int         start_cnt [128];
    int         starts_total = 0;
    logic       s_pull = 1'b0;
    int         s_ph = PH_IDLE;
    int         s_cnt = 0;
    logic [7:0] s_sh = 8'h00;
    logic [7:0] s_byte = 8'h00;
    logic       p_scl = 1'b1;
    logic       p_sda = 1'b1;
    logic       v_prev = 1'b0;

    assign sda_in = !(sda_oe || s_pull);

    i2c_poll_master #(
        .CLK_DIV    (4),
        .NUM_SLAVES (4),
        .BASE_ADDR  (7'h7E)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .sweep_req   (sweep_req),
        .busy        (busy),
        .scl         (scl),
        .sda_oe      (sda_oe),
        .sda_in      (sda_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_addr    (res_addr),
        .res_err     (res_err),
        .o_dbg_state (dbg_state)
    );

    // clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // I2C slave model, evaluated away from the DUT's active edge
    always @(negedge clk) begin
        logic sda_now;
        sda_now = !(sda_oe || s_pull);
        if (p_scl && scl && p_sda && !sda_now) begin
            s_ph = PH_ADDR;
            s_cnt = 0;
            s_pull = 1'b0;
        end else if (p_scl && scl && !p_sda && sda_now) begin
            s_ph = PH_IDLE;
            s_pull = 1'b0;
        end else if (!p_scl && scl) begin
            if (s_ph == PH_ADDR && s_cnt < 8) begin
                s_sh = {s_sh[6:0], sda_now};
                s_cnt++;
            end
        end else if (p_scl && !scl) begin
            case (s_ph)
                PH_ADDR: begin
                    if (s_cnt == 8) begin
                        starts_total++;
                        start_cnt[s_sh[7:1]]++;
                        if (present[s_sh[7:1]] && s_sh[0]) begin
                            s_pull = 1'b1;
                            s_byte = mem[s_sh[7:1]];
                            s_ph = PH_ACK;
                        end else begin
                            s_ph = PH_IDLE;
                        end
                    end
                end
                PH_ACK: begin
                    s_ph = PH_DATA;
                    s_cnt = 0;
                    s_pull = !s_byte[7];
                end
                PH_DATA: begin
                    s_cnt++;
                    if (s_cnt < 8) begin
                        s_pull = !s_byte[7 - s_cnt];
                    end else begin
                        s_pull = 1'b0;
                        s_ph = PH_IDLE;
                    end
                end
                default: ;
            endcase
        end
        p_scl = scl;
        p_sda = !(sda_oe || s_pull);
    end

    // scoreboard monitor: pops and compares at every result handshake
    always @(negedge clk) begin
        if (res_valid && !v_prev) rise_q.push_back(cyc);
        v_prev = res_valid;
        if (res_valid && res_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL result_unexpected: got err=%0b addr=%h data=%h, want none", res_err, res_addr, res_data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if ({res_err, res_addr, res_data} !== e) begin
                    bad++;
                    $display("FAIL result: got err=%0b addr=%h data=%h, want err=%0b addr=%h data=%h",
                             res_err, res_addr, res_data, e[15], e[14:8], e[7:0]);
                end
            end
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL busy_at_handshake: got %0b, want 1", busy);
            end
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    task automatic pulse_sweep();
        @(posedge clk); #1 sweep_req = 1'b1;
        @(posedge clk); #1 sweep_req = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic push_exp(input logic err, input logic [6:0] addr, input logic [7:0] data);
        exp_q.push_back({err, addr, data});
    endtask

    task automatic push_full_sweep();
        push_exp(1'b0, 7'h7E, 8'hA5);
        push_exp(1'b0, 7'h7F, 8'h3C);
        push_exp(1'b1, 7'h00, 8'h00);
        push_exp(1'b0, 7'h01, 8'h5A);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d results pending, want 0 within %0d clks", name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    initial begin
        int st0;
        int exp_starts;
        logic [15:0] snap;

        for (int i = 0; i < 128; i++) begin
            mem[i] = 8'h00;
            present[i] = 1'b0;
            start_cnt[i] = 0;
        end
        mem[7'h7E] = 8'hA5; present[7'h7E] = 1'b1;
        mem[7'h7F] = 8'h3C; present[7'h7F] = 1'b1;
        mem[7'h01] = 8'h5A; present[7'h01] = 1'b1;

        // reset values
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_scl", int'(scl), 1);
        check("rst_sda_oe", int'(sda_oe), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_res_data", int'(res_data), 0);
        check("rst_res_addr", int'(res_addr), 0);
        check("rst_res_err", int'(res_err), 0);
        check("rst_state", int'(dbg_state), 0);

        // full sweep with ready high; sweep_req while busy must be ignored
        rise_q.delete();
        push_full_sweep();
        pulse_sweep();
        repeat (100) @(posedge clk);
        #1 sweep_req = 1'b1;
        @(posedge clk); #1 sweep_req = 1'b0;
        wait_drain("sweep_a", 2500);
        check("first_valid_latency", (rise_q.size() > 0) ? rise_q[0] - acc_cyc : -1, 313);
        check("slave_spacing", (rise_q.size() > 1) ? rise_q[1] - rise_q[0] : -1, 314);
`ifdef I2C_POLL_RETRY_EN
        exp_starts = 2;
`else
        exp_starts = 1;
`endif
        check("starts_for_absent_slave", start_cnt[7'h00], exp_starts);
        repeat (20) @(negedge clk);
        check("idle_after_sweep_busy", int'(busy), 0);
        check("idle_after_sweep_valid", int'(res_valid), 0);

        // backpressure: ready low for 50 clks after the first result
        res_ready = 1'b0;
        push_full_sweep();
        pulse_sweep();
        begin
            int n;
            n = 0;
            while (!res_valid && n < 400) begin
                @(negedge clk);
                n++;
            end
            check("bp_first_valid_seen", int'(res_valid), 1);
        end
        snap = {res_err, res_addr, res_data};
        st0 = starts_total;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("bp_res_stable", int'({res_err, res_addr, res_data}), int'(snap));
            check("bp_valid_held", int'(res_valid), 1);
            check("bp_bus_idle", int'({scl, sda_oe}), 2);
            check("bp_no_new_start", starts_total, st0);
        end
        @(posedge clk); #1 res_ready = 1'b1;
        wait_drain("sweep_bp", 2500);

        // en dropped during DATA of slave 0: only slave 0 completes
        st0 = starts_total;
        push_exp(1'b0, 7'h7E, 8'hA5);
        pulse_sweep();
        repeat (200) @(posedge clk);
        #1 en = 1'b0;
        wait_drain("sweep_en", 1000);
        check("en_drop_busy", int'(busy), 0);
        repeat (400) @(negedge clk);
        check("en_drop_single_start", starts_total - st0, 1);
        check("en_drop_stays_idle", int'(busy), 0);
        @(posedge clk); #1 en = 1'b1;

        // reset in the 3rd address slot, then a clean sweep
        pulse_sweep();
        repeat (43) @(posedge clk);
        @(negedge clk);
        check("pre_reset_in_addr", int'(dbg_state), 2);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("mid_rst_scl", int'(scl), 1);
        check("mid_rst_sda_oe", int'(sda_oe), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_valid", int'(res_valid), 0);
        repeat (10) @(posedge clk);
        push_full_sweep();
        pulse_sweep();
        wait_drain("sweep_after_rst", 2500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global bound on run time
    initial begin
        #800000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/i2c_poll_master.md
# i2c_poll_master

Single-master I2C read sequencer for the sensor bus. It sweeps a contiguous range of slave addresses and performs one single-byte read per slave: START, 7-bit address with R=1, slave ACK, 8 data bits, master NACK, STOP. Each byte is delivered on a valid/ready result port. It sits between the tag digital core and the I2C measurement slaves; it generates SCL from the system clock and drives SDA open-drain.

## Interface

Parameters:
- CLK_DIV, 4: system clocks per SCL quarter-period; legal range 2..255.
- NUM_SLAVES, 4: slaves polled per sweep; legal range 1..8.
- BASE_ADDR, 7'h20: address of slave 0; slave i is BASE_ADDR+i, 7-bit wrap.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high.
- en  in  1  global enable; sampled only in IDLE and between slaves.
- sweep_req  in  1  one-cycle pulse that starts a sweep; ignored while busy.
- busy  out  1  high from sweep accept to end of the last result handshake.
- scl  out  1  push-pull SCL; idle 1.
- sda_oe  out  1  1 = pull SDA low, 0 = release; pad wired as `sda = sda_oe ? 0 : z` with pull-up.
- sda_in  in  1  SDA pad value.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  8  byte read; 8'h00 on error.
- res_addr  out  7  slave address of the result.
- res_err  out  1  slave did not ACK its address.

## Operation

- Reset values: scl=1, sda_oe=0, busy=0, res_valid=0, res_data=0, res_addr=0, res_err=0, slave index=0, FSM=IDLE.
- Quarter tick: a prescaler counts 0..CLK_DIV-1, reset to 0 on leaving IDLE or WAIT. Every FSM action below happens on a tick.
- Bit slot, 4 quarters: Q0 scl=0 and SDA updated; Q1 scl=0; Q2 scl=1; Q3 scl=1 and sda_in sampled.
- States:
  - IDLE: sweep_req && en -> START, with index=0 and busy=1.
  - START: Q0 sda_oe=1 while scl=1; Q1 hold -> ADDR.
  - ADDR: 8 slots sending addr[6:0] MSB-first, then 1 (read) -> AACK.
  - AACK: SDA released. sda_in=0 at Q3 -> DATA. sda_in=1 -> STOP with err flagged.
  - DATA: 8 slots, SDA released, shifting in MSB-first -> MNACK.
  - MNACK: SDA released (NACK), so the slave returns to its idle state -> STOP.
  - STOP: Q0 scl=0 sda_oe=1; Q1 hold; Q2 scl=1; Q3 sda_oe=0 -> OUT.
  - OUT: load res_*, res_valid=1 -> WAIT.
  - WAIT: hold until res_valid && res_ready. Then: if index==NUM_SLAVES-1 or !en -> IDLE with busy=0; else index+1 -> START.
- Bus stays idle (scl=1, SDA released) in IDLE, OUT and WAIT.
- Deasserting en mid-transaction does not abort it. The current slave completes, and the sweep ends after its handshake.
- Reset mid-transaction forces the reset values on the next clk edge. The resulting SDA release may look like a STOP on the bus; this is acceptable, because slaves resynchronise on the next START.
- Address arithmetic: BASE_ADDR+index truncated to 7 bits, so 7'h7F+1 = 7'h00.

## Timing

- Transaction: 2+36+36+4 = 78 quarters.
- res_valid rises exactly 78*CLK_DIV+1 clks after the sweep_req accept edge, or after the previous handshake edge for the following slaves.
- res_* stay stable while res_valid=1 && !res_ready.
- res_valid falls the clk after the handshake.
- The next START begins on the handshake edge.
- With res_ready tied high, consecutive slaves are spaced 78*CLK_DIV+2 clks apart.
- sweep_req arriving on the same edge as the last handshake is ignored; busy is still 1 on that edge.

## Configuration

- I2C_POLL_RETRY_EN defined: on an address NACK, the FSM issues STOP, then one repeated attempt (full START..AACK) for the same slave. res_err=1 only if the retry also NACKs. A failed slave therefore costs 2×78 quarters.
- I2C_POLL_RETRY_EN undefined: no retry; the first address NACK yields res_err=1 and res_data=8'h00.

## Test plan

- Reset, CLK_DIV=4, NUM_SLAVES=2, slaves at 7'h20 and 7'h21 holding measurements 8'hA5 and 8'h3C, res_ready=1, sweep_req pulse -> results (7'h20,8'hA5,err 0) then (7'h21,8'h3C,err 0); first res_valid 313 clks after accept; busy falls after the 2nd handshake.
- No slave at 7'h21 -> second result (7'h21,8'h00,err 1). Without the macro, exactly one START on the bus for 7'h21; with I2C_POLL_RETRY_EN, exactly two.
- res_ready held 0 for 50 clks after the first res_valid -> res_* stable; scl=1 and SDA released throughout; second START only after the handshake.
- en dropped during the DATA phase of slave 0 in a 4-slave sweep -> slave 0 completes with correct data, no START for slave 1, busy=0 after the handshake.
- reset asserted at the 3rd ADDR slot -> next clk: scl=1, sda_oe=0, busy=0, res_valid=0. A subsequent sweep reads correct data, confirming slave resynchronisation.
- BASE_ADDR=7'h7F, NUM_SLAVES=2 -> res_addr sequence 7'h7F, 7'h00.
